// File: rtl/instr_fetch.sv
// instr_fetch: in-order fetch stage around the PC register; accepted requests reach decode 1 cycle after their response, up to 1 instr/cycle.
// Requests stop when queue + in-flight reach QDEPTH; decode back-pressure holds the head stable. `FETCH_PERF_CNT_EN adds stall/flush counters.
module instr_fetch #(
    parameter int unsigned QDEPTH     = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [31:0] next_addr_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int unsigned IW = $clog2(QDEPTH);
    localparam int unsigned PW = IW + 1;

    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t           PTR_ONE = ptr_t'(1);
    localparam logic [PW:0]    QD      = QDEPTH[PW:0];

    ptr_t              wr_ptr_q, wr_ptr_d, fill_ptr_q, fill_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d, drop_cnt_q, drop_cnt_d;
    logic [QDEPTH-1:0] filled_q, filled_d;
    logic [31:0]       pc_q    [QDEPTH];
    logic [31:0]       pc_d    [QDEPTH];
    logic [31:0]       instr_q [QDEPTH];
    logic [31:0]       instr_d [QDEPTH];

    logic [IW-1:0] wr_idx, fill_idx, rd_idx;
    ptr_t          occ;
    logic [PW:0]   inflight;
    logic          full, req_acc, rsp_fill, rsp_drop, deq;

    assign wr_idx   = wr_ptr_q[IW-1:0];
    assign fill_idx = fill_ptr_q[IW-1:0];
    assign rd_idx   = rd_ptr_q[IW-1:0];

    // Responses still owed to dropped requests count against capacity too.
    assign occ      = wr_ptr_q - rd_ptr_q;
    assign inflight = {1'b0, occ} + {1'b0, drop_cnt_q};
    assign full     = (inflight >= QD);

    assign imem_req_valid_o = !rst && !redirect_i && !full;
    assign imem_req_addr_o  = pc_i;
    assign req_acc          = imem_req_valid_o && imem_req_ready_i;

    assign rsp_drop = imem_rsp_valid_i && (drop_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid_i && (drop_cnt_q == '0);

    assign id_valid_o = !rst && filled_q[rd_idx] && (rd_ptr_q != fill_ptr_q);
    assign id_instr_o = instr_q[rd_idx];
    assign id_pc_o    = pc_q[rd_idx];
    assign deq        = id_valid_o && id_ready_i;

    always_comb begin
        next_addr_o = pc_i;
        if (rst)
            next_addr_o = RESET_ADDR;
        else if (redirect_i)
            next_addr_o = {redirect_addr_i[31:2], 2'b00};
        else if (req_acc)
            next_addr_o = pc_i + 32'd4;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        filled_d   = filled_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if (redirect_i) begin
            // Everything requested but not yet returned becomes a drop, minus this cycle's response.
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            filled_d   = '0;
            drop_cnt_d = (wr_ptr_q - fill_ptr_q) + drop_cnt_q
                         - {{(PW-1){1'b0}}, imem_rsp_valid_i};
        end else begin
            if (req_acc) begin
                pc_d[wr_idx]     = pc_i;
                filled_d[wr_idx] = 1'b0;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end
            if (rsp_drop)
                drop_cnt_d = drop_cnt_q - PTR_ONE;
            if (rsp_fill) begin
                instr_d[fill_idx]  = imem_rsp_data_i;
                filled_d[fill_idx] = 1'b1;
                fill_ptr_d         = fill_ptr_q + PTR_ONE;
            end
            if (deq) begin
                filled_d[rd_idx] = 1'b0;
                rd_ptr_d         = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            filled_q   <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!redirect_i && full && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_i && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

`ifndef SYNTHESIS
    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid_i |-> ((fill_ptr_q != wr_ptr_q) || (drop_cnt_q != '0)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC register and in-order latency memory modelled here, per-cycle vector table plus corner sequences.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] next_addr_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    instr_fetch #(.QDEPTH(4), .RESET_ADDR(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .next_addr_o      (next_addr_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_addr_i  (redirect_addr_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int deq_n  = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    typedef struct {
        logic        rst, rdy, idr;
        logic        req;
        logic [31:0] nxt;
        logic        idv;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[18];

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic idr,
                         input logic rd, input logic [31:0] ra);
        rst              = r;
        imem_req_ready_i = rdy;
        id_ready_i       = idr;
        redirect_i       = rd;
        redirect_addr_i  = ra;
        #2;
    endtask

    // Closes the current cycle: scoreboard, clock edge, then PC register and memory update.
    task automatic tick();
        logic        acc, rsp_was, redir, was_rst;
        logic [31:0] nxt, ra, aa;
        int          c0;
        acc     = imem_req_valid_o && imem_req_ready_i;
        aa      = imem_req_addr_o;
        nxt     = next_addr_o;
        rsp_was = imem_rsp_valid_i;
        redir   = redirect_i;
        ra      = redirect_addr_i;
        was_rst = rst;
        c0      = cyc;
        if (was_rst) begin
            exp_pc = 32'h0;
        end else if (redir) begin
            exp_pc = {ra[31:2], 2'b00};
        end else if (id_valid_o && id_ready_i) begin
            chk("deq_pc", id_pc_o, exp_pc);
            chk("deq_instr", id_instr_o, word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deq_n++;
        end
        @(posedge clk);
        #1;
        cyc  = cyc + 1;
        pc_i = nxt;
        if (was_rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (rsp_was && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (acc) begin
                mq_addr.push_back(aa);
                mq_due.push_back(c0 + lat);
            end
        end
        imem_rsp_valid_i = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_data_i  = imem_rsp_valid_i ? word(mq_addr[0]) : 32'h0;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic run(input int n, input logic rdy, input logic idr);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, rdy, idr, 1'b0, 32'h0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset row, then decode stalled 10 cycles from the first fetch, then released (lat 1).
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h00};
        for (int i = 5; i <= 10; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h04};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h08};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h0C};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h10};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h14};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h18};

        pc_i             = 32'h0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        lat              = 1;

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_b("por_req_vld", imem_req_valid_o, 1'b0);
        chk("por_next", next_addr_o, 32'h0);
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].idr, 1'b0, 32'h0);
            chk_b($sformatf("row%0d_req_vld", i), imem_req_valid_o, tbl[i].req);
            chk($sformatf("row%0d_next", i), next_addr_o, tbl[i].nxt);
            chk_b($sformatf("row%0d_id_vld", i), id_valid_o, tbl[i].idv);
            if (i > 0)
                chk($sformatf("row%0d_req_addr", i), imem_req_addr_o, tbl[i-1].nxt);
            if (tbl[i].idv)
                chk($sformatf("row%0d_id_pc", i), id_pc_o, tbl[i].pc);
            tick();
        end

        // Redirect to 0x100 with two responses in flight (lat 3).
        lat = 3;
        do_reset();
        run(2, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        chk_b("rd3_req_vld", imem_req_valid_o, 1'b0);
        chk("rd3_next", next_addr_o, 32'h100);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk_b($sformatf("rd3_idle%0d_id_vld", k), id_valid_o, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_b("rd3_first_vld", id_valid_o, 1'b1);
        chk("rd3_first_pc", id_pc_o, 32'h100);
        tick();
        run(6, 1'b1, 1'b1);

        // Misaligned redirect while a response arrives and the head is being dequeued (lat 2).
        lat = 2;
        do_reset();
        run(3, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
        chk_b("rd4_id_vld", id_valid_o, 1'b1);
        chk("rd4_id_pc", id_pc_o, 32'h0);
        chk_b("rd4_req_vld", imem_req_valid_o, 1'b0);
        chk("rd4_next", next_addr_o, 32'h200);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk_b($sformatf("rd4_idle%0d_id_vld", k), id_valid_o, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_b("rd4_first_vld", id_valid_o, 1'b1);
        chk("rd4_first_pc", id_pc_o, 32'h200);
        chk("rd4_first_instr", id_instr_o, word(32'h200));
        tick();
        run(6, 1'b1, 1'b1);

        // Memory back-pressure 1,0,1,0: 20 fetches, pointers wrap several times.
        lat = 1;
        do_reset();
        deq_n = 0;
        begin
            logic [31:0] exp_addr;
            exp_addr = 32'h0;
            for (int k = 0; k < 40; k++) begin
                drive(1'b0, (k % 2) == 0, 1'b1, 1'b0, 32'h0);
                chk_b($sformatf("bp%0d_req_vld", k), imem_req_valid_o, 1'b1);
                chk($sformatf("bp%0d_req_addr", k), imem_req_addr_o, exp_addr);
                chk($sformatf("bp%0d_next", k), next_addr_o,
                    ((k % 2) == 0) ? exp_addr + 32'd4 : exp_addr);
                if ((k % 2) == 0)
                    exp_addr = exp_addr + 32'd4;
                tick();
            end
        end
        run(4, 1'b0, 1'b1);
        chk("bp_deq_count", deq_n, 20);
        chk("bp_last_pc", exp_pc, 32'h50);

        // Reset with three instructions queued.
        lat = 1;
        do_reset();
        run(3, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_b("rm_pre_id_vld", id_valid_o, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_b("rm_rst_req_vld", imem_req_valid_o, 1'b0);
        chk("rm_rst_next", next_addr_o, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_b("rm_after_id_vld", id_valid_o, 1'b0);
        chk_b("rm_after_req_vld", imem_req_valid_o, 1'b0);
        chk("rm_after_next", next_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rm_stall_cnt", stall_cnt_o, 32'h0);
        chk("rm_flush_cnt", flush_cnt_o, 32'h0);
`endif
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_b("rm_restart_req_vld", imem_req_valid_o, 1'b1);
        chk("rm_restart_addr", imem_req_addr_o, 32'h0);
        chk_b("rm_restart_id_vld", id_valid_o, 1'b0);
        tick();
        deq_n = 0;
        run(8, 1'b1, 1'b1);
        chk("rm_deq_count", deq_n, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage wrapped around the PC register. Drives the PC register's NextAddr and reads back its Addr. Issues in-order instruction-memory requests and buffers returned instructions with their PCs in a small in-order queue. Presents the instructions to decode through a valid/ready handshake and handles branch/jump redirects by flushing the queue and discarding in-flight responses.

Parameters:
QDEPTH, 4, fetch queue entries; power of 2, at least 2; also caps total outstanding requests.
RESET_ADDR, 32'h0000_0000, value driven on next_addr_o while rst is high.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
pc_i  input  32  current PC, from the PC register's Addr output.
next_addr_o  output  32  next PC, to the PC register's NextAddr input.
imem_req_valid_o  output  1  fetch request valid.
imem_req_ready_i  input  1  instruction memory accepts the request.
imem_req_addr_o  output  32  fetch address; always equals pc_i.
imem_rsp_valid_i  input  1  response valid; responses return in order, at least 1 cycle after acceptance, and are never back-pressured.
imem_rsp_data_i  input  32  instruction word.
redirect_i  input  1  flush and redirect, from execute.
redirect_addr_i  input  32  redirect target.
id_valid_o  output  1  instruction available to decode.
id_ready_i  input  1  decode accepts.
id_instr_o  output  32  instruction at the queue head.
id_pc_o  output  32  PC of the instruction at the queue head.

Behaviour:
- State:
  - Queue of QDEPTH entries {pc, instr, filled}.
  - Pointers: wr_ptr (allocate), fill_ptr (oldest unfilled), rd_ptr (head). Each is log2(QDEPTH)+1 bits and wraps naturally.
  - drop_cnt: log2(QDEPTH)+1 bits.
  - occ = wr_ptr - rd_ptr.
- Reset, in the cycle rst is high and after the edge:
  - All pointers and drop_cnt = 0; all filled bits = 0.
  - imem_req_valid_o = 0, id_valid_o = 0, next_addr_o = RESET_ADDR.
- Request issue:
  - imem_req_valid_o = !rst && !redirect_i && (occ + drop_cnt < QDEPTH).
  - Acceptance = imem_req_valid_o && imem_req_ready_i. On acceptance: write {pc_i, filled=0} at wr_ptr, then wr_ptr++.
- Next-PC mux, priority order:
  - rst -> RESET_ADDR.
  - redirect_i -> {redirect_addr_i[31:2], 2'b00}.
  - acceptance -> pc_i + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - otherwise -> pc_i (hold).
- Response handling:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Else: write instr at fill_ptr, set filled, fill_ptr++.
- Output to decode:
  - id_valid_o = filled[rd_ptr] && (rd_ptr != fill_ptr... i.e. the entry is valid). id_instr_o and id_pc_o are taken from the rd_ptr entry.
  - Dequeue when id_valid_o && id_ready_i: clear filled, rd_ptr++.
  - Outputs hold stable while id_valid_o=1 and id_ready_i=0.
- Latency: request accepted at cycle N, response at N+k; id_valid_o=1 at N+k+1. Best-case steady-state throughput is 1 instruction per cycle.
- Redirect, at the clock edge with redirect_i=1:
  - All queue entries are invalidated: wr_ptr = fill_ptr = rd_ptr = 0, filled cleared.
  - drop_cnt becomes (wr_ptr - fill_ptr) + drop_cnt, minus 1 if a response arrives in that same cycle. The same-cycle response is itself discarded.
  - Any dequeue in that cycle is void; id_valid_o = 0 in the following cycle.
- Boundary conditions:
  - Full (occ + drop_cnt == QDEPTH): no requests issued; next_addr_o holds pc_i.
  - Simultaneous enqueue, fill and dequeue on the same entry index is legal.
  - Reset in the middle of outstanding requests: state cleared and no drop accounting. The system resets the memory at the same time.
- Assertions (simulation only): response arriving with no outstanding request (fill_ptr == wr_ptr and drop_cnt == 0) is an error.

Optional Feature:
Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [31:0]: increments in each cycle where imem_req_valid_o=0 because of the full condition.
  - Adds output flush_cnt_o [31:0]: increments on each redirect_i.
  - Both counters are reset to 0 by rst and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Sequential stream, zero wait:
  - Stimulus: reset with RESET_ADDR=0; ready=1; 1-cycle memory latency; decode always ready.
  - Required: next_addr_o = 4, 8, C, ...; id_pc_o = 0, 4, 8 on consecutive cycles, starting 2 cycles after the first accept; id_instr_o matches the memory contents.
- Decode stall:
  - Stimulus: id_ready_i=0 for 10 cycles.
  - Required: exactly QDEPTH=4 requests issued; then imem_req_valid_o=0 and next_addr_o == pc_i; id_pc_o holds 0.
  - On release: 4 instructions in order, followed by the fetch at 0x10.
- Redirect with in-flight responses:
  - Stimulus: 3-cycle latency memory; redirect_i to 0x100 while 2 responses are outstanding.
  - Required: those 2 responses are dropped; the first id_pc_o after the redirect is 0x100; no stale instruction reaches decode.
- Redirect, response in the same cycle, misaligned target:
  - Stimulus: redirect_addr_i = 0x203 in a cycle with imem_rsp_valid_i=1.
  - Required: next_addr_o = 0x200; the response is discarded; drop_cnt is reduced by 1.
- Memory back-pressure and wrap:
  - Stimulus: imem_req_ready_i toggling 1,0,1,0.
  - Required: PC advances only on accept cycles; imem_req_addr_o stays stable while not accepted; pointers wrap past QDEPTH with no loss or reorder over 20 instructions.
- Reset mid-operation:
  - Stimulus: rst=1 with 3 entries queued.
  - Required: id_valid_o=0 and imem_req_valid_o=0 next cycle; next_addr_o = RESET_ADDR.
  - With FETCH_PERF_CNT_EN: stall_cnt_o and flush_cnt_o read 0.
